// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM state
// type and default/limit values for the parameters.
// Build option: define REG_FILE_MP_BYPASS_EN for write-to-read forwarding.
package reg_file_mp_pkg;

  // Clear sweep sequencer states; IDLE is the reset state
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

  // Default geometry of the register file
  localparam int DATA_W_DEFAULT = 8;
  localparam int ADDR_W_DEFAULT = 3;
  localparam int NUM_RD_DEFAULT = 2;

  // Largest number of read ports the file is meant to be built with
  localparam int NUM_RD_MAX = 4;

  // True when a read-port count lies inside the supported range
  function automatic bit num_rd_legal(input int n);
    return (n >= 1) && (n <= NUM_RD_MAX);
  endfunction

endpackage

// File: rtl/reg_file_mp_clr_seq.sv
// Clear sweep sequencer for reg_file_mp: a two-state FSM plus the sweep
// pointer. While sweeping, one register per cycle is zeroed at address ptr;
// the sweep ends on the edge that zeroes the last register.
module reg_file_mp_clr_seq
  import reg_file_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  output logic              busy,
  output logic              sweep_en,
  output logic [ADDR_W-1:0] ptr
);

  // The last address equals all ones, so the pointer wraps naturally
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state;
  clr_state_t        state_next;
  logic [ADDR_W-1:0] ptr_next;

  // State and pointer registers; reset aborts any sweep in progress
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state logic: CLEAR only matters in IDLE, so a sweep can be neither
  // restarted nor stretched once it is running
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        ptr_next = ptr + 1'b1;
        if (ptr == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Both flags come straight from the state register, never from inputs
  assign busy     = (state == SWEEP);
  assign sweep_en = (state == SWEEP);

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one synchronous write port, NUM_RD independent
// combinational read ports, and a sequential clear sweep that zeroes one
// register per cycle. Writes arriving during a sweep are rejected and
// flagged on WR_DROP one cycle later.
// Build option: define REG_FILE_MP_BYPASS_EN to forward a write that will be
// accepted at the next edge onto any read port addressing the same register.
// NUM_RD is intended to stay within 1..NUM_RD_MAX (see reg_file_mp_pkg).
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int NUM_RD = NUM_RD_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [DATA_W-1:0]        IN,
  input  logic [ADDR_W-1:0]        INADDRESS,
  input  logic                     WRITE,
  input  logic                     CLEAR,
  input  logic [NUM_RD*ADDR_W-1:0] OUTADDRESS,
  output logic [NUM_RD*DATA_W-1:0] OUT,
  output logic                     BUSY,
  output logic                     WR_DROP
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              sweep_en;
  logic [ADDR_W-1:0] ptr;
  logic              write_ok;

  // A write is only honoured while no sweep is running
  assign write_ok = WRITE && !BUSY;

  reg_file_mp_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear    (CLEAR),
    .busy     (BUSY),
    .sweep_en (sweep_en),
    .ptr      (ptr)
  );

  // Storage: sweep zeroing takes priority; a simultaneous WRITE+CLEAR in
  // IDLE still lands because the sweep only begins on the following edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (sweep_en) begin
      regs[ptr] <= '0;
    end else if (write_ok) begin
      regs[INADDRESS] <= IN;
    end
  end

  // Rejected-write flag, high for the single cycle after the dropped write
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WR_DROP <= 1'b0;
    end else begin
      WR_DROP <= WRITE && BUSY;
    end
  end

  // Read ports are independent muxes over the storage array
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = OUTADDRESS[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_MP_BYPASS_EN
    assign OUT[k*DATA_W +: DATA_W] =
      (write_ok && !RESET && (rd_addr == INADDRESS)) ? IN : regs[rd_addr];
`else
    assign OUT[k*DATA_W +: DATA_W] = regs[rd_addr];
`endif
  end

endmodule
